// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the registered multi-lane half adder.
package half_adder_pkg;

    localparam int unsigned HA_WIDTH_DEFAULT = 1;
    localparam int unsigned HA_WIDTH_MIN     = 1;
    localparam int unsigned HA_WIDTH_MAX     = 64;

    // Bits needed to hold a population count of 0..w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes behind a one-deep valid/ready output register,
// with a registered popcount of the carry vector.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = HA_WIDTH_DEFAULT,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [CNT_W-1:0] carry_count
);

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;
    logic [CNT_W-1:0] cnt_c;
    logic             accept_c;

    // Lanes are fully independent: no carry chain between cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (sum_c[i]),
            .carry (carry_c[i])
        );
    end

    // Popcount of the carry vector that is about to be registered.
    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_c = cnt_c + CNT_W'(carry_c[i]);
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // Valid bit: cleared on drain-only, held under backpressure, set on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
        end
    end

    // Result registers only move when new operands are accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum         <= '0;
            carry       <= '0;
            carry_count <= '0;
        end else if (accept_c) begin
            sum         <= sum_c;
            carry       <= carry_c;
            carry_count <= cnt_c;
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder at WIDTH=1, 8 and 4.
module tb_half_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv1, ir1, ov1, or1;
    logic [0:0] a1, b1, s1, c1, n1;
    logic       iv8, ir8, ov8, or8;
    logic [7:0] a8, b8, s8, c8;
    logic [3:0] n8;
    logic       iv4, ir4, ov4, or4;
    logic [3:0] a4, b4, s4, c4;
    logic [2:0] n4;

    half_adder #(.WIDTH(1)) u_ha1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1), .carry_count(n1));
    half_adder #(.WIDTH(8)) u_ha8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .carry(c8), .carry_count(n8));
    half_adder #(.WIDTH(4)) u_ha4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .carry(c4), .carry_count(n4));

    typedef struct {
        logic [63:0] s;
        logic [63:0] c;
        logic [63:0] n;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    exp_t q4[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int d, input logic [63:0] s, input logic [63:0] c,
                       input logic [63:0] n);
        exp_t e;
        int   sz;
        sz = (d == 1) ? q1.size() : (d == 8) ? q8.size() : q4.size();
        if (sz == 0) begin
            tests++;
            fails++;
            $display("FAIL out%0d_unexpected: got sum %0h with no expected result at %0t",
                     d, s, $time);
        end else begin
            if (d == 1)      e = q1.pop_front();
            else if (d == 8) e = q8.pop_front();
            else             e = q4.pop_front();
            chk($sformatf("out%0d_sum", d), s, e.s);
            chk($sformatf("out%0d_carry", d), c, e.c);
            chk($sformatf("out%0d_count", d), n, e.n);
        end
    endtask

    // Output monitor: every consumed result is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            q8.delete();
            q4.delete();
        end else begin
            if (ov1 && or1) mon(1, 64'(s1), 64'(c1), 64'(n1));
            if (ov8 && or8) mon(8, 64'(s8), 64'(c8), 64'(n8));
            if (ov4 && or4) mon(4, 64'(s4), 64'(c4), 64'(n4));
        end
    end

    function automatic logic rdy(input int d);
        return (d == 1) ? ir1 : (d == 8) ? ir8 : ir4;
    endfunction

    // Present operands, push the expected result on the accepting edge.
    task automatic send(input int d, input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] es, input logic [63:0] ec, input logic [63:0] en);
        exp_t e;
        bit   done;
        done = 1'b0;
        e.s = es;
        e.c = ec;
        e.n = en;
        if (d == 1)      begin a1 = av[0:0]; b1 = bv[0:0]; iv1 = 1'b1; end
        else if (d == 8) begin a8 = av[7:0]; b8 = bv[7:0]; iv8 = 1'b1; end
        else             begin a4 = av[3:0]; b4 = bv[3:0]; iv4 = 1'b1; end
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (rdy(d)) begin
                if (d == 1)      q1.push_back(e);
                else if (d == 8) q8.push_back(e);
                else             q4.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send%0d_timeout: in_ready stayed 0 expected 1", d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {iv1, iv8, iv4} = '0;
        {or1, or8, or4} = 3'b111;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        #2;
        chk("rst_ov8", 64'(ov8), 64'd0);
        chk("rst_sum8", 64'(s8), 64'd0);
        chk("rst_carry8", 64'(c8), 64'd0);
        chk("rst_cnt8", 64'(n8), 64'd0);
        chk("rst_ir8", 64'(ir8), 64'd1);
        chk("rst_ov1", 64'(ov1), 64'd0);
        chk("rst_ir1", 64'(ir1), 64'd1);
        chk("rst_ov4", 64'(ov4), 64'd0);
        chk("rst_ir4", 64'(ir4), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Truth table, WIDTH=1.
        send(1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        chk("tt_latency_ov", 64'(ov1), 64'd1);
        send(1, 64'd0, 64'd1, 64'd1, 64'd0, 64'd0);
        send(1, 64'd1, 64'd0, 64'd1, 64'd0, 64'd0);
        send(1, 64'd1, 64'd1, 64'd0, 64'd1, 64'd1);
        iv1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Wide lanes, then drain-only keeps data.
        send(8, 64'hF0, 64'h3C, 64'hCC, 64'h30, 64'd2);
        chk("wide_latency_sum", 64'(s8), 64'hCC);
        send(8, 64'hFF, 64'hFF, 64'h00, 64'hFF, 64'd8);
        iv8 = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_ov", 64'(ov8), 64'd0);
        chk("drain_sum", 64'(s8), 64'h00);
        chk("drain_carry", 64'(c8), 64'hFF);
        chk("drain_cnt", 64'(n8), 64'd8);

        // Backpressure: result held, operands ignored, consumed once.
        or8 = 1'b0;
        send(8, 64'hF0, 64'h3C, 64'hCC, 64'h30, 64'd2);
        for (int i = 0; i < 3; i++) begin
            a8 = 8'(8'h11 * (i + 1));
            b8 = ~a8;
            iv8 = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_sum", 64'(s8), 64'hCC);
            chk("bp_carry", 64'(c8), 64'h30);
            chk("bp_cnt", 64'(n8), 64'd2);
            chk("bp_ov", 64'(ov8), 64'd1);
            chk("bp_ir", 64'(ir8), 64'd0);
        end
        or8 = 1'b1;
        iv8 = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release_ov", 64'(ov8), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Streaming at full throughput, WIDTH=4.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ai;
            ai = 4'(i);
            send(4, 64'(ai), 64'h5, 64'(ai ^ 4'h5), 64'(ai & 4'h5), 64'($countones(ai & 4'h5)));
            chk("stream_ov", 64'(ov4), 64'd1);
        end
        iv4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset while a result is held.
        or8 = 1'b0;
        send(8, 64'h0F, 64'h01, 64'h0E, 64'h01, 64'd1);
        iv8 = 1'b0;
        chk("mid_pre_ov", 64'(ov8), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(ov8), 64'd0);
        chk("mid_rst_sum", 64'(s8), 64'd0);
        chk("mid_rst_carry", 64'(c8), 64'd0);
        chk("mid_rst_cnt", 64'(n8), 64'd0);
        chk("mid_rst_ir", 64'(ir8), 64'd1);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        or8 = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ov", 64'(ov8), 64'd0);
        send(8, 64'h33, 64'h0F, 64'h3C, 64'h03, 64'd2);
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("q1_empty", 64'(q1.size()), 64'd0);
        chk("q8_empty", 64'(q8.size()), 64'd0);
        chk("q4_empty", 64'(q4.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
